// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, opcode/funct3 constants, FSM state type and
// the access-legality helper for the memory stage.
package mem_stage_pkg;

    localparam int unsigned DWIDTH        = 32;
    localparam int unsigned CPU_ADDR_BITS = 32;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_e;

    // Legal size for the opcode class and naturally aligned address.
    function automatic logic access_legal(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        if (is_load) begin
            case (f3)
                FNC_LB, FNC_LBU: ok = 1'b1;
                FNC_LH, FNC_LHU: ok = ~addr_lo[0];
                FNC_LW:          ok = (addr_lo == 2'b00);
                default:         ok = 1'b0;
            endcase
        end else begin
            case (f3)
                FNC_SB:  ok = 1'b1;
                FNC_SH:  ok = ~addr_lo[0];
                FNC_SW:  ok = (addr_lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: valid/ready request channel plus read-response channel
// between the memory stage (master) and the data memory/cache (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                     dmem_req_valid;
    logic                     dmem_req_ready;
    logic [CPU_ADDR_BITS-1:0] dmem_req_addr;
    logic [3:0]               dmem_req_wmask;
    logic [DWIDTH-1:0]        dmem_req_wdata;
    logic                     dmem_resp_valid;
    logic [DWIDTH-1:0]        dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_addr, dmem_req_wmask, dmem_req_wdata,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_addr, dmem_req_wmask, dmem_req_wdata,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

endinterface

// File: rtl/mem_stage_load_extend.sv
// load_extend: selects the byte/half/word addressed by a load from the
// returned memory word and sign- or zero-extends it.
//   i_funct3  : load size/signedness
//   i_addr_lo : byte offset within the word
//   i_rdata   : raw read word
//   o_data    : aligned, extended result
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic [DWIDTH-1:0] i_rdata,
    output logic [DWIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = '0;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = i_rdata;
        case (i_funct3)
            FNC_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            FNC_LBU: o_data = {24'd0, w_byte};
            FNC_LH:  o_data = {{16{w_half[15]}}, w_half};
            FNC_LHU: o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: accepts load/store ops from execute, issues one blocking data
// memory access at a time, and returns aligned load data to writeback.
//   clk, rst          : clock, async active-high reset
//   in_valid/in_ready : execute handshake (in_ready == IDLE)
//   opcode..rd        : operation fields from execute
//   dmem              : request/response channel to data memory
//   wb_valid/rd/data  : one-cycle load result to writeback
//   fault             : one-cycle pulse for a dropped illegal access
//   stall             : upstream stall while an access is outstanding
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [CPU_ADDR_BITS-1:0] mem_addr,
    input  logic [DWIDTH-1:0]        mem_data,
    input  logic [4:0]               rd,
    mem_stage_if.master              dmem,
    output logic                     wb_valid,
    output logic [4:0]               wb_rd,
    output logic [DWIDTH-1:0]        wb_data,
    output logic                     fault,
    output logic                     stall
);

    mem_state_e r_state, w_next;

    logic                     r_is_load;
    logic [4:0]               r_rd;
    logic [2:0]               r_funct3;
    logic [1:0]               r_addr_lo;
    logic [CPU_ADDR_BITS-1:0] r_req_addr;
    logic [3:0]               r_req_wmask;
    logic [DWIDTH-1:0]        r_req_wdata;
    logic                     r_wb_valid;
    logic [4:0]               r_wb_rd;
    logic [DWIDTH-1:0]        r_wb_data;
    logic                     r_fault;

    logic              w_accept, w_is_load, w_is_store, w_mem_op, w_legal;
    logic              w_start, w_resp;
    logic [3:0]        w_wmask;
    logic [DWIDTH-1:0] w_wdata;
    logic [DWIDTH-1:0] w_ext;

    assign in_ready   = (r_state == MEM_IDLE);
    assign stall      = (r_state != MEM_IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_is_load  = (opcode == OPC_LOAD);
    assign w_is_store = (opcode == OPC_STORE);
    assign w_mem_op   = w_is_load | w_is_store;
    assign w_legal    = access_legal(w_is_load, funct3, mem_addr[1:0]);
    assign w_start    = w_accept & w_mem_op & w_legal;
    assign w_resp     = (r_state == MEM_WAIT) & dmem.dmem_resp_valid;

    // Store lane enables and lane-replicated data; loads send a zero mask.
    always_comb begin
        w_wmask = '0;
        w_wdata = '0;
        if (w_is_store) begin
            case (funct3)
                FNC_SB: begin
                    w_wmask = 4'b0001 << mem_addr[1:0];
                    w_wdata = {4{mem_data[7:0]}};
                end
                FNC_SH: begin
                    w_wmask = 4'b0011 << {mem_addr[1], 1'b0};
                    w_wdata = {2{mem_data[15:0]}};
                end
                FNC_SW: begin
                    w_wmask = 4'hF;
                    w_wdata = mem_data;
                end
                default: begin
                    w_wmask = '0;
                    w_wdata = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MEM_IDLE: if (w_start) w_next = MEM_REQ;
            MEM_REQ:  if (dmem.dmem_req_ready) w_next = r_is_load ? MEM_WAIT : MEM_IDLE;
            MEM_WAIT: if (dmem.dmem_resp_valid) w_next = MEM_IDLE;
            default:  w_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= MEM_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_load   <= 1'b0;
            r_rd        <= '0;
            r_funct3    <= '0;
            r_addr_lo   <= '0;
            r_req_addr  <= '0;
            r_req_wmask <= '0;
            r_req_wdata <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_fault     <= 1'b0;
        end else begin
            if (w_start) begin
                r_is_load   <= w_is_load;
                r_rd        <= rd;
                r_funct3    <= funct3;
                r_addr_lo   <= mem_addr[1:0];
                r_req_addr  <= {mem_addr[CPU_ADDR_BITS-1:2], 2'b00};
                r_req_wmask <= w_wmask;
                r_req_wdata <= w_wdata;
            end
            r_fault    <= w_accept & w_mem_op & ~w_legal;
            r_wb_valid <= w_resp;
            if (w_resp) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ext;
            end
        end
    end

    load_extend u_load_extend (
        .i_funct3  (r_funct3),
        .i_addr_lo (r_addr_lo),
        .i_rdata   (dmem.dmem_resp_rdata),
        .o_data    (w_ext)
    );

    assign dmem.dmem_req_valid = (r_state == MEM_REQ);
    assign dmem.dmem_req_addr  = r_req_addr;
    assign dmem.dmem_req_wmask = r_req_wmask;
    assign dmem.dmem_req_wdata = r_req_wdata;

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign fault    = r_fault;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven checks of mem_stage plus hand-written
// sequences for stalled handshakes, back-to-back accept and mid-access reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic        stall;

    mem_stage_if u_if ();

    mem_stage dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .funct3   (funct3),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .rd       (rd),
        .dmem     (u_if.master),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fault    (fault),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] resp;
        logic [4:0]  rd;
        logic        exp_fault;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[14];

    task automatic drive_op(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] r);
        in_valid = 1'b1; opcode = o; funct3 = f; mem_addr = a; mem_data = d; rd = r;
    endtask

    task automatic idle_op();
        in_valid = 1'b0; opcode = '0; funct3 = '0; mem_addr = '0; mem_data = '0; rd = '0;
    endtask

    // Drive on negedge, DUT captures on posedge, check on the next negedge.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        drive_op(v.opc, v.f3, v.addr, v.data, v.rd);
        @(negedge clk);
        idle_op();
        chk({tag, " fault"}, {31'd0, fault}, {31'd0, v.exp_fault});
        chk({tag, " req_valid"}, {31'd0, u_if.dmem_req_valid}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            chk({tag, " req_addr"}, u_if.dmem_req_addr, v.exp_addr);
            chk({tag, " wmask"}, {28'd0, u_if.dmem_req_wmask}, {28'd0, v.exp_wmask});
            if (v.exp_wmask != 4'd0) chk({tag, " wdata"}, u_if.dmem_req_wdata, v.exp_wdata);
        end
        if (!v.exp_req) begin
            @(negedge clk);
            chk({tag, " fault_clr"}, {31'd0, fault}, 32'd0);
            chk({tag, " no_req"}, {31'd0, u_if.dmem_req_valid}, 32'd0);
            chk({tag, " no_wb"}, {31'd0, wb_valid}, 32'd0);
            return;
        end
        @(negedge clk);
        chk({tag, " req_done"}, {31'd0, u_if.dmem_req_valid}, 32'd0);
        if (v.exp_wb) begin
            u_if.dmem_resp_valid = 1'b1;
            u_if.dmem_resp_rdata = v.resp;
            @(negedge clk);
            u_if.dmem_resp_valid = 1'b0;
            u_if.dmem_resp_rdata = '0;
            chk({tag, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
            chk({tag, " wb_data"}, wb_data, v.exp_wb_data);
            chk({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, v.rd});
            @(negedge clk);
            chk({tag, " wb_pulse"}, {31'd0, wb_valid}, 32'd0);
        end else begin
            chk({tag, " idle"}, {31'd0, in_ready}, 32'd1);
            chk({tag, " st_no_wb"}, {31'd0, wb_valid}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          opc        f3      addr          data          resp          rd   flt  req  exp_addr      wmask    wdata         wb   wb_data
        vecs[0]  = '{OPC_STORE, FNC_SW,  32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         5'd0, 1'b0, 1'b1, 32'h0000_1000, 4'hF,    32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{OPC_STORE, FNC_SB,  32'h0000_1003, 32'h0000_00A5, 32'h0,         5'd0, 1'b0, 1'b1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[2]  = '{OPC_STORE, FNC_SH,  32'h0000_1002, 32'h1234_ABCD, 32'h0,         5'd0, 1'b0, 1'b1, 32'h0000_1000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
        vecs[3]  = '{OPC_LOAD,  FNC_LB,  32'h0000_2002, 32'h0,         32'h1180_2233, 5'd3, 1'b0, 1'b1, 32'h0000_2000, 4'h0,    32'h0,         1'b1, 32'hFFFF_FF80};
        vecs[4]  = '{OPC_LOAD,  FNC_LBU, 32'h0000_2002, 32'h0,         32'h1180_2233, 5'd4, 1'b0, 1'b1, 32'h0000_2000, 4'h0,    32'h0,         1'b1, 32'h0000_0080};
        vecs[5]  = '{OPC_LOAD,  FNC_LHU, 32'h0000_2002, 32'h0,         32'h1180_2233, 5'd5, 1'b0, 1'b1, 32'h0000_2000, 4'h0,    32'h0,         1'b1, 32'h0000_1180};
        vecs[6]  = '{OPC_LOAD,  FNC_LH,  32'h0000_2000, 32'h0,         32'h1180_8233, 5'd6, 1'b0, 1'b1, 32'h0000_2000, 4'h0,    32'h0,         1'b1, 32'hFFFF_8233};
        vecs[7]  = '{OPC_LOAD,  FNC_LW,  32'h0000_2004, 32'h0,         32'hCAFE_F00D, 5'd31,1'b0, 1'b1, 32'h0000_2004, 4'h0,    32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[8]  = '{OPC_LOAD,  FNC_LB,  32'h0000_2001, 32'h0,         32'h1180_2233, 5'd8, 1'b0, 1'b1, 32'h0000_2000, 4'h0,    32'h0,         1'b1, 32'h0000_0022};
        vecs[9]  = '{OPC_LOAD,  FNC_LW,  32'h0000_3001, 32'h0,         32'h0,         5'd9, 1'b1, 1'b0, 32'h0,         4'h0,    32'h0,         1'b0, 32'h0};
        vecs[10] = '{OPC_STORE, FNC_SH,  32'h0000_3003, 32'h0000_FFFF, 32'h0,         5'd0, 1'b1, 1'b0, 32'h0,         4'h0,    32'h0,         1'b0, 32'h0};
        vecs[11] = '{OPC_LOAD,  3'b011,  32'h0000_3000, 32'h0,         32'h0,         5'd2, 1'b1, 1'b0, 32'h0,         4'h0,    32'h0,         1'b0, 32'h0};
        vecs[12] = '{7'b0110011, 3'b000, 32'h0000_3000, 32'h0,         32'h0,         5'd2, 1'b0, 1'b0, 32'h0,         4'h0,    32'h0,         1'b0, 32'h0};
        vecs[13] = '{OPC_LOAD,  FNC_LW,  32'h0000_2008, 32'h0,         32'h1234_5678, 5'd0, 1'b0, 1'b1, 32'h0000_2008, 4'h0,    32'h0,         1'b1, 32'h1234_5678};

        rst = 1'b1;
        idle_op();
        u_if.dmem_req_ready  = 1'b1;
        u_if.dmem_resp_valid = 1'b0;
        u_if.dmem_resp_rdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst req_valid", {31'd0, u_if.dmem_req_valid}, 32'd0);
        chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst fault", {31'd0, fault}, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst req_addr", u_if.dmem_req_addr, 32'd0);
        chk("rst wmask", {28'd0, u_if.dmem_req_wmask}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // LW with ready low for 3 cycles, response 2 cycles after handshake,
        // then a store accepted in the same cycle wb_valid is high.
        u_if.dmem_req_ready = 1'b0;
        @(negedge clk);
        drive_op(OPC_LOAD, FNC_LW, 32'h0000_4008, 32'h0, 5'd7);
        @(negedge clk);
        idle_op();
        for (int i = 0; i < 3; i++) begin
            chk("stl req_valid", {31'd0, u_if.dmem_req_valid}, 32'd1);
            chk("stl req_addr", u_if.dmem_req_addr, 32'h0000_4008);
            chk("stl wmask", {28'd0, u_if.dmem_req_wmask}, 32'd0);
            chk("stl stall", {31'd0, stall}, 32'd1);
            chk("stl in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        u_if.dmem_req_ready = 1'b1;
        @(negedge clk);
        chk("stl hs req_valid", {31'd0, u_if.dmem_req_valid}, 32'd0);
        chk("stl wait stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("stl wait2 stall", {31'd0, stall}, 32'd1);
        chk("stl wait2 in_ready", {31'd0, in_ready}, 32'd0);
        chk("stl wait2 no_wb", {31'd0, wb_valid}, 32'd0);
        u_if.dmem_resp_valid = 1'b1;
        u_if.dmem_resp_rdata = 32'h89AB_CDEF;
        @(negedge clk);
        u_if.dmem_resp_valid = 1'b0;
        u_if.dmem_resp_rdata = '0;
        chk("stl wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("stl wb_data", wb_data, 32'h89AB_CDEF);
        chk("stl wb_rd", {27'd0, wb_rd}, 32'd7);
        chk("stl b2b in_ready", {31'd0, in_ready}, 32'd1);
        drive_op(OPC_STORE, FNC_SW, 32'h0000_4010, 32'h5566_7788, 5'd0);
        @(negedge clk);
        idle_op();
        chk("b2b wb_pulse", {31'd0, wb_valid}, 32'd0);
        chk("b2b req_valid", {31'd0, u_if.dmem_req_valid}, 32'd1);
        chk("b2b req_addr", u_if.dmem_req_addr, 32'h0000_4010);
        chk("b2b wmask", {28'd0, u_if.dmem_req_wmask}, 32'hF);
        chk("b2b wdata", u_if.dmem_req_wdata, 32'h5566_7788);
        @(negedge clk);
        chk("b2b done", {31'd0, in_ready}, 32'd1);
        chk("b2b no_wb", {31'd0, wb_valid}, 32'd0);

        // Reset while waiting for a load response, then a late response.
        @(negedge clk);
        drive_op(OPC_LOAD, FNC_LW, 32'h0000_5000, 32'h0, 5'd9);
        @(negedge clk);
        idle_op();
        chk("rw req_valid", {31'd0, u_if.dmem_req_valid}, 32'd1);
        @(negedge clk);
        chk("rw wait stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rw rst stall", {31'd0, stall}, 32'd0);
        chk("rw rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rw rst req_valid", {31'd0, u_if.dmem_req_valid}, 32'd0);
        chk("rw rst wb_data", wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rw wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rw req_addr", u_if.dmem_req_addr, 32'd0);
        u_if.dmem_resp_valid = 1'b1;
        u_if.dmem_resp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        u_if.dmem_resp_valid = 1'b0;
        u_if.dmem_resp_rdata = '0;
        chk("rw late no_wb", {31'd0, wb_valid}, 32'd0);
        chk("rw late wb_data", wb_data, 32'd0);
        chk("rw late in_ready", {31'd0, in_ready}, 32'd1);
        run_vec(vecs[6], "rw after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
